cmt_multi: RTL and testbench
============================

Name: cmt_multi

Overview:
- Parametrised multi-lane commit collector for difftest.
- Sits after writeback. Registers up to LANES retiring instructions per cycle and detects the trap instruction (opcode 7'h6b) on the lowest-index lane.
- Keeps cycle/instruction counters, halts cleanly on trap, and flags lane-ordering violations.
- Its registered outputs drive the difftest commit, trap and regfile-snapshot interfaces for all lanes.

Parameters:
- LANES, 2, commit lanes per cycle (1..4)
- XLEN, 64, data/PC width
- RIDX_W, 5, register index width
- CNT_W, 64, cycle/instr counter width
- TIMEOUT, 4096, cycles with no valid commit before watchdog trap (used only with CMT_WATCHDOG_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- i_valid  in  LANES  per-lane commit valid; valid lanes must form a prefix starting at lane 0
- i_skip  in  LANES  per-lane difftest skip
- i_pc  in  LANES*XLEN  per-lane PC, lane k at [k*XLEN +: XLEN]
- i_inst  in  LANES*32  per-lane instruction
- i_rd_wen  in  LANES  per-lane rd write enable
- i_rd  in  LANES*RIDX_W  per-lane rd index
- i_rd_wdata  in  LANES*XLEN  per-lane rd write data
- i_a0  in  XLEN  architectural a0 as seen by the trapping instruction
- o_cmt_valid  out  LANES  registered commit valid
- o_cmt_skip  out  LANES  registered skip
- o_cmt_pc  out  LANES*XLEN  registered PC
- o_cmt_inst  out  LANES*32  registered instruction
- o_cmt_wen  out  LANES  registered rd wen
- o_cmt_wdest  out  LANES*8  rd index, zero-extended to 8 bits
- o_cmt_wdata  out  LANES*XLEN  registered wdata
- o_trap  out  1  trap event valid; sticky while halted
- o_trap_code  out  8  i_a0[7:0] at trap, or 8'hFF on watchdog
- o_trap_pc  out  XLEN  PC of the trapping lane
- o_cycle_cnt  out  CNT_W  cycles since reset
- o_instr_cnt  out  CNT_W  committed instructions
- o_order_err  out  1  sticky: non-prefix i_valid seen

Behaviour:
- Reset: all outputs 0; state RUN; counters 0; watchdog counter 0.
- States and transitions:
  - RUN → HALT on trap detect or watchdog expiry.
  - HALT → HALT until reset; no other exit.
- Latency: one cycle. Inputs sampled on the rising edge of clk; outputs are valid in the following cycle.
- Trap detect, in RUN: t = lowest k with i_valid[k] && i_inst[k][6:0]==7'h6b.
  - Lanes above t are masked: o_cmt_valid[j>t]=0.
  - Lane t itself commits.
  - o_trap=1 next cycle, with o_trap_pc = lane t PC and o_trap_code = i_a0[7:0].
- Instruction counting: o_instr_cnt += popcount of the masked valid lanes. Increment width is clog2(LANES+1), zero-extended.
- Cycle counting: o_cycle_cnt += 1 every RUN cycle. Both counters wrap modulo 2^CNT_W.
- In HALT:
  - Inputs are ignored and all outputs frozen.
  - Exception: o_cmt_valid and o_cmt_skip are cleared one cycle after entering HALT, so the commit is emitted exactly once.
  - Counters frozen.
- Ordering check: if i_valid is not of the form 0..01..1, set o_order_err (sticky) and still commit every valid lane as given. The trap rule still applies to the lowest valid lane.
- Lane with i_valid=0: its payload registers still update; its o_cmt_valid is 0.
- Reset asserted mid-operation, including in HALT: immediate return to reset values.

Optional Feature:
- Macro: CMT_WATCHDOG_EN.
- Defined:
  - In RUN, the watchdog counter increments on every cycle with no valid lane and clears on any valid commit.
  - At TIMEOUT it enters HALT with o_trap=1, o_trap_code=8'hFF and o_trap_pc = the last committed PC.
  - A real trap in the same cycle takes priority.
- Undefined: no watchdog logic; HALT is entered only on a trap instruction.

Decomposition:
- Shared package/defines:
  - TRAP_OPCODE 7'h6b
  - WDOG_TRAP_CODE 8'hFF
  - state encoding RUN=1'b0, HALT=1'b1
- Sub-module cmt_lane_mask (combinational): takes i_valid plus per-lane trap hits and produces the masked valid vector, trap lane index, trap-hit flag, popcount and prefix-error flag.

Test Plan:
- LANES=2, 10 cycles with i_valid=2'b11 and non-trap inst → o_instr_cnt=20, o_cycle_cnt=10, o_cmt_valid=2'b11 each cycle after the first.
- Lane0 inst=32'h0000006b, a0=0, lane1 valid → o_cmt_valid=2'b01, o_trap=1, o_trap_code=0, o_trap_pc=lane0 PC, instr_cnt +1. Then valid clears next cycle and counters freeze.
- Lane1 trap with a0=64'h5 → both lanes commit, o_trap_code=8'h05, instr_cnt +2.
- i_valid=2'b10 → o_order_err=1 and stays 1; lane1 commits and instr_cnt +1.
- Reset pulse while in HALT → all outputs 0 asynchronously; after release, commits resume in RUN.
- With CMT_WATCHDOG_EN, TIMEOUT=16: 16 idle cycles → o_trap=1, o_trap_code=8'hFF. Without the macro the same stimulus never raises o_trap.

Source files
------------

// File: rtl/cmt_multi_pkg.sv
// Shared constants and types for the multi-lane commit collector.
// Optional watchdog is enabled with CMT_WATCHDOG_EN.
package cmt_multi_pkg;

  localparam logic [6:0] TRAP_OPCODE    = 7'h6b;
  localparam logic [7:0] WDOG_TRAP_CODE = 8'hFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } cmt_state_e;

  function automatic int idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int pop_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/cmt_lane_mask.sv
// Masks lanes above the first trap, counts commits and
// flags valid vectors that are not a prefix from lane 0.
module cmt_lane_mask
  import cmt_multi_pkg::*;
#(
  parameter int LANES = 2,
  parameter int IW    = idx_w(LANES),
  parameter int PW    = pop_w(LANES)
) (
  input  logic [LANES-1:0] valid_i,
  input  logic [LANES-1:0] hit_i,
  output logic [LANES-1:0] mask_o,
  output logic [IW-1:0]    trap_idx_o,
  output logic             trap_o,
  output logic [PW-1:0]    pop_o,
  output logic             order_err_o
);

  logic found;

  always_comb begin
    mask_o     = '0;
    trap_idx_o = '0;
    pop_o      = '0;
    found      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!found) begin
        mask_o[k] = valid_i[k];
        if (valid_i[k] && hit_i[k]) begin
          found      = 1'b1;
          trap_idx_o = IW'(k);
        end
      end
      pop_o = pop_o + PW'(mask_o[k]);
    end
  end

  assign trap_o = found;

  // a prefix of ones plus one has no bit in common with itself
  assign order_err_o = |(valid_i & (valid_i + LANES'(1)));

endmodule

// File: rtl/cmt_multi.sv
// Multi-lane difftest commit collector with trap halt.
// Watchdog trap on idle commit stream with CMT_WATCHDOG_EN.
module cmt_multi
  import cmt_multi_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int XLEN    = 64,
  parameter int RIDX_W  = 5,
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        i_valid,
  input  logic [LANES-1:0]        i_skip,
  input  logic [LANES*XLEN-1:0]   i_pc,
  input  logic [LANES*32-1:0]     i_inst,
  input  logic [LANES-1:0]        i_rd_wen,
  input  logic [LANES*RIDX_W-1:0] i_rd,
  input  logic [LANES*XLEN-1:0]   i_rd_wdata,
  input  logic [XLEN-1:0]         i_a0,
  output logic [LANES-1:0]        o_cmt_valid,
  output logic [LANES-1:0]        o_cmt_skip,
  output logic [LANES*XLEN-1:0]   o_cmt_pc,
  output logic [LANES*32-1:0]     o_cmt_inst,
  output logic [LANES-1:0]        o_cmt_wen,
  output logic [LANES*8-1:0]      o_cmt_wdest,
  output logic [LANES*XLEN-1:0]   o_cmt_wdata,
  output logic                    o_trap,
  output logic [7:0]              o_trap_code,
  output logic [XLEN-1:0]         o_trap_pc,
  output logic [CNT_W-1:0]        o_cycle_cnt,
  output logic [CNT_W-1:0]        o_instr_cnt,
  output logic                    o_order_err
);

  localparam int IW = idx_w(LANES);
  localparam int PW = pop_w(LANES);

  cmt_state_e state_q, state_d;

  logic [LANES-1:0]      valid_q, valid_d;
  logic [LANES-1:0]      skip_q, skip_d;
  logic [LANES*XLEN-1:0] pc_q, pc_d;
  logic [LANES*32-1:0]   inst_q, inst_d;
  logic [LANES-1:0]      wen_q, wen_d;
  logic [LANES*8-1:0]    wdest_q, wdest_d;
  logic [LANES*XLEN-1:0] wdata_q, wdata_d;
  logic                  trap_q, trap_d;
  logic [7:0]            code_q, code_d;
  logic [XLEN-1:0]       tpc_q, tpc_d;
  logic [CNT_W-1:0]      cyc_q, cyc_d;
  logic [CNT_W-1:0]      icnt_q, icnt_d;
  logic                  oerr_q, oerr_d;

  logic [LANES-1:0] hit;
  logic [LANES-1:0] mask;
  logic [IW-1:0]    tidx;
  logic             thit;
  logic [PW-1:0]    pop;
  logic             perr;

  logic unused_a0;
  assign unused_a0 = ^i_a0[XLEN-1:8];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      hit[k] = (i_inst[k*32 +: 7] == TRAP_OPCODE);
    end
  end

  cmt_lane_mask #(
    .LANES (LANES),
    .IW    (IW),
    .PW    (PW)
  ) u_mask (
    .valid_i     (i_valid),
    .hit_i       (hit),
    .mask_o      (mask),
    .trap_idx_o  (tidx),
    .trap_o      (thit),
    .pop_o       (pop),
    .order_err_o (perr)
  );

`ifdef CMT_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0]   wd_q, wd_d;
  logic [XLEN-1:0] lpc_q, lpc_d;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    skip_d  = skip_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    wen_d   = wen_q;
    wdest_d = wdest_q;
    wdata_d = wdata_q;
    trap_d  = trap_q;
    code_d  = code_q;
    tpc_d   = tpc_q;
    cyc_d   = cyc_q;
    icnt_d  = icnt_q;
    oerr_d  = oerr_q;
`ifdef CMT_WATCHDOG_EN
    wd_d    = wd_q;
    lpc_d   = lpc_q;
`endif
    case (state_q)
      RUN: begin
        valid_d = mask;
        skip_d  = i_skip;
        pc_d    = i_pc;
        inst_d  = i_inst;
        wen_d   = i_rd_wen;
        wdata_d = i_rd_wdata;
        for (int k = 0; k < LANES; k++) begin
          wdest_d[k*8 +: 8] = 8'(i_rd[k*RIDX_W +: RIDX_W]);
        end
        cyc_d  = cyc_q + CNT_W'(1);
        icnt_d = icnt_q + CNT_W'(pop);
        oerr_d = oerr_q | perr;
`ifdef CMT_WATCHDOG_EN
        wd_d = (|i_valid) ? '0 : wd_q + WW'(1);
        for (int k = 0; k < LANES; k++) begin
          if (mask[k]) lpc_d = i_pc[k*XLEN +: XLEN];
        end
`endif
        if (thit) begin
          state_d = HALT;
          trap_d  = 1'b1;
          code_d  = i_a0[7:0];
          tpc_d   = i_pc[int'(tidx)*XLEN +: XLEN];
        end
`ifdef CMT_WATCHDOG_EN
        else if (!(|i_valid) && (int'(wd_q) + 1 >= TIMEOUT)) begin
          state_d = HALT;
          trap_d  = 1'b1;
          code_d  = WDOG_TRAP_CODE;
          tpc_d   = lpc_q;
        end
`endif
      end
      HALT: begin
        // commit pulse is emitted once, the rest stays frozen
        valid_d = '0;
        skip_d  = '0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      valid_q <= '0;
      skip_q  <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      wen_q   <= '0;
      wdest_q <= '0;
      wdata_q <= '0;
      trap_q  <= 1'b0;
      code_q  <= '0;
      tpc_q   <= '0;
      cyc_q   <= '0;
      icnt_q  <= '0;
      oerr_q  <= 1'b0;
`ifdef CMT_WATCHDOG_EN
      wd_q    <= '0;
      lpc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      skip_q  <= skip_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      wen_q   <= wen_d;
      wdest_q <= wdest_d;
      wdata_q <= wdata_d;
      trap_q  <= trap_d;
      code_q  <= code_d;
      tpc_q   <= tpc_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
      oerr_q  <= oerr_d;
`ifdef CMT_WATCHDOG_EN
      wd_q    <= wd_d;
      lpc_q   <= lpc_d;
`endif
    end
  end

  assign o_cmt_valid = valid_q;
  assign o_cmt_skip  = skip_q;
  assign o_cmt_pc    = pc_q;
  assign o_cmt_inst  = inst_q;
  assign o_cmt_wen   = wen_q;
  assign o_cmt_wdest = wdest_q;
  assign o_cmt_wdata = wdata_q;
  assign o_trap      = trap_q;
  assign o_trap_code = code_q;
  assign o_trap_pc   = tpc_q;
  assign o_cycle_cnt = cyc_q;
  assign o_instr_cnt = icnt_q;
  assign o_order_err = oerr_q;

endmodule

// File: tb/tb_cmt_multi.sv
// Bench for cmt_multi: vector table, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_cmt_multi;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h0000_006b;
  localparam logic [63:0] PC0  = 64'h8000_0000;
  localparam logic [63:0] PC1  = 64'h8000_0004;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   vld, skp, wen;
  logic [127:0] pc, wdata;
  logic [63:0]  inst;
  logic [9:0]   rd;
  logic [63:0]  a0;

  logic [1:0]   ov, os, owen;
  logic [127:0] opc, owdata;
  logic [63:0]  oinst;
  logic [15:0]  owd;
  logic         otrap, oerr;
  logic [7:0]   ocode;
  logic [63:0]  otpc, ocyc, oicnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmt_multi #(
    .LANES(2), .XLEN(64), .RIDX_W(5), .CNT_W(64), .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (vld),
    .i_skip      (skp),
    .i_pc        (pc),
    .i_inst      (inst),
    .i_rd_wen    (wen),
    .i_rd        (rd),
    .i_rd_wdata  (wdata),
    .i_a0        (a0),
    .o_cmt_valid (ov),
    .o_cmt_skip  (os),
    .o_cmt_pc    (opc),
    .o_cmt_inst  (oinst),
    .o_cmt_wen   (owen),
    .o_cmt_wdest (owd),
    .o_cmt_wdata (owdata),
    .o_trap      (otrap),
    .o_trap_code (ocode),
    .o_trap_pc   (otpc),
    .o_cycle_cnt (ocyc),
    .o_instr_cnt (oicnt),
    .o_order_err (oerr)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [63:0] a);
    vld  = v;
    inst = {i1, i0};
    a0   = a;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [63:0] a;
    logic [1:0]  ev;
    logic        et;
    logic [7:0]  ec;
    logic [63:0] epc;
    logic [63:0] en;
    logic        eo;
  } vec_t;

  vec_t tbl[9];

  // behavioural model state
  logic        m_halt;
  int          m_age;
  logic [63:0] m_cyc, m_icnt, m_tpc, m_cpc0, m_lpc;
  logic        m_trap, m_oerr;
  logic [7:0]  m_code;
  logic [1:0]  m_valid, m_skip;
  int          m_idle;

  task automatic m_reset();
    m_halt = 0; m_age = 0; m_cyc = 0; m_icnt = 0; m_tpc = 0;
    m_cpc0 = 0; m_lpc = 0; m_trap = 0; m_oerr = 0; m_code = 0;
    m_valid = 0; m_skip = 0; m_idle = 0;
  endtask

  initial begin
    rst = 1'b1;
    vld = 0; skp = 0; wen = 2'b11;
    pc = {PC1, PC0}; wdata = '0; inst = {NOP, NOP};
    rd = {5'd3, 5'd7}; a0 = '0;
    #12;
    chk("rst_valid", 64'(ov), 0);
    chk("rst_trap", 64'(otrap), 0);
    chk("rst_cyc", ocyc, 0);
    chk("rst_icnt", oicnt, 0);
    chk("rst_pc", opc[63:0], 0);
    chk("rst_oerr", 64'(oerr), 0);
    rst = 1'b0;

    // ten full-width commits
    drive(2'b11, NOP, NOP, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("burst_valid", 64'(ov), 64'(2'b11));
    end
    chk("burst_icnt", oicnt, 20);
    chk("burst_cyc", ocyc, 10);
    chk("burst_wdest", 64'(owd), 64'({8'd3, 8'd7}));

    tbl[0] = '{2'b11, NOP,  NOP,  64'h0,   2'b11, 0, 8'h00, 0,   2, 0};
    tbl[1] = '{2'b01, NOP,  NOP,  64'h0,   2'b01, 0, 8'h00, 0,   1, 0};
    tbl[2] = '{2'b00, NOP,  NOP,  64'h0,   2'b00, 0, 8'h00, 0,   0, 0};
    tbl[3] = '{2'b10, NOP,  NOP,  64'h0,   2'b10, 0, 8'h00, 0,   1, 1};
    tbl[4] = '{2'b11, TRAP, NOP,  64'h0,   2'b01, 1, 8'h00, PC0, 1, 0};
    tbl[5] = '{2'b11, NOP,  TRAP, 64'h5,   2'b11, 1, 8'h05, PC1, 2, 0};
    tbl[6] = '{2'b10, NOP,  TRAP, 64'h1a7, 2'b10, 1, 8'ha7, PC1, 1, 1};
    tbl[7] = '{2'b01, NOP,  TRAP, 64'h9,   2'b01, 0, 8'h00, 0,   1, 0};
    tbl[8] = '{2'b11, TRAP, TRAP, 64'h3,   2'b01, 1, 8'h03, PC0, 1, 0};
    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive(tbl[i].v, tbl[i].i0, tbl[i].i1, tbl[i].a);
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(ov), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_trap", i), 64'(otrap), 64'(tbl[i].et));
      chk($sformatf("tbl%0d_code", i), 64'(ocode), 64'(tbl[i].ec));
      chk($sformatf("tbl%0d_tpc", i), otpc, tbl[i].epc);
      chk($sformatf("tbl%0d_icnt", i), oicnt, tbl[i].en);
      chk($sformatf("tbl%0d_oerr", i), 64'(oerr), 64'(tbl[i].eo));
    end

    // halt freezes everything except the commit pulse
    do_reset();
    pc = {PC1, 64'h100};
    drive(2'b11, TRAP, NOP, 64'h42);
    tick();
    chk("halt_enter_trap", 64'(otrap), 1);
    chk("halt_enter_code", 64'(ocode), 64'h42);
    chk("halt_enter_tpc", otpc, 64'h100);
    pc = {64'h300, 64'h200};
    drive(2'b11, NOP, NOP, 64'h77);
    tick();
    chk("halt_valid_clr", 64'(ov), 0);
    chk("halt_trap_held", 64'(otrap), 1);
    chk("halt_icnt", oicnt, 1);
    chk("halt_cyc", ocyc, 1);
    chk("halt_pc_frozen", opc[63:0], 64'h100);
    tick();
    chk("halt_cyc2", ocyc, 1);
    chk("halt_code2", 64'(ocode), 64'h42);

    // asynchronous reset while halted
    rst = 1'b1;
    #1;
    chk("arst_trap", 64'(otrap), 0);
    chk("arst_cyc", ocyc, 0);
    chk("arst_pc", opc[63:0], 0);
    rst = 1'b0;
    drive(2'b01, NOP, NOP, 0);
    tick();
    chk("resume_valid", 64'(ov), 64'(2'b01));
    chk("resume_icnt", oicnt, 1);
    chk("resume_trap", 64'(otrap), 0);

    // order error is sticky
    do_reset();
    drive(2'b10, NOP, NOP, 0);
    tick();
    chk("oerr_set", 64'(oerr), 1);
    chk("oerr_valid", 64'(ov), 64'(2'b10));
    drive(2'b11, NOP, NOP, 0);
    tick();
    chk("oerr_sticky", 64'(oerr), 1);
    chk("oerr_icnt", oicnt, 3);

    // idle stream: watchdog fires after 16 idle cycles when built in
    do_reset();
    pc = {PC1, 64'h240};
    drive(2'b01, NOP, NOP, 0);
    tick();
    drive(2'b00, NOP, NOP, 0);
    for (int c = 0; c < 15; c++) tick();
    chk("wdog_pre", 64'(otrap), 0);
    tick();
`ifdef CMT_WATCHDOG_EN
    chk("wdog_trap", 64'(otrap), 1);
    chk("wdog_code", 64'(ocode), 64'hFF);
    chk("wdog_tpc", otpc, 64'h240);
`else
    chk("wdog_none", 64'(otrap), 0);
    for (int c = 0; c < 8; c++) tick();
    chk("wdog_none_late", 64'(otrap), 0);
`endif

    // randomized traffic against the model
    do_reset();
    m_reset();
    for (int c = 0; c < 600; c++) begin
      logic [1:0]  v;
      logic [31:0] w[2];
      int t, nv;
      logic [1:0]  mv;
      case ($urandom_range(0, 5))
        0: v = 2'b00;
        1: v = 2'b01;
        2: v = 2'b10;
        default: v = 2'b11;
      endcase
      for (int k = 0; k < 2; k++) begin
        w[k] = $urandom;
        if ($urandom_range(0, 9) == 0) w[k][6:0] = 7'h6b;
        else if (w[k][6:0] == 7'h6b) w[k][0] = ~w[k][0];
      end
      pc  = {$urandom, $urandom, $urandom, $urandom};
      skp = 2'($urandom);
      drive(v, w[0], w[1], {$urandom, $urandom});

      if (!m_halt) begin
        t = -1;
        for (int k = 0; k < 2; k++)
          if (t < 0 && v[k] && w[k][6:0] == 7'h6b) t = k;
        mv = 0;
        for (int k = 0; k < 2; k++)
          if (v[k] && (t < 0 || k <= t)) mv[k] = 1'b1;
        nv = $countones(v);
        if (int'(v) != (1 << nv) - 1) m_oerr = 1;
        m_cyc++;
        m_icnt += 64'($countones(mv));
        m_valid = mv;
        m_skip = skp;
        m_cpc0 = pc[63:0];
        m_idle = (v == 0) ? m_idle + 1 : 0;
        if (t >= 0) begin
          m_halt = 1; m_trap = 1; m_code = a0[7:0];
          m_tpc = pc[t*64 +: 64];
        end
`ifdef CMT_WATCHDOG_EN
        else if (m_idle >= 16) begin
          m_halt = 1; m_trap = 1; m_code = 8'hFF; m_tpc = m_lpc;
        end
`endif
        for (int k = 0; k < 2; k++)
          if (mv[k]) m_lpc = pc[k*64 +: 64];
      end else begin
        m_valid = 0;
        m_skip = 0;
        m_age++;
      end

      tick();
      chk("rnd_valid", 64'(ov), 64'(m_valid));
      chk("rnd_skip", 64'(os), 64'(m_skip));
      chk("rnd_pc0", opc[63:0], m_cpc0);
      chk("rnd_trap", 64'(otrap), 64'(m_trap));
      chk("rnd_cyc", ocyc, m_cyc);
      chk("rnd_icnt", oicnt, m_icnt);
      chk("rnd_oerr", 64'(oerr), 64'(m_oerr));
      if (m_trap) begin
        chk("rnd_code", 64'(ocode), 64'(m_code));
        chk("rnd_tpc", otpc, m_tpc);
      end
      if (m_halt && m_age >= 2) begin
        do_reset();
        m_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
